// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch port, data port, flush/stall and the memory bus of the arbiter.
// slave is the arbiter's view; master is the view of the CPU and memory around it.
interface mem_bus_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ready;
   logic        i_err;
   logic [31:0] i_rdata;

   logic        d_req;
   logic [3:0]  d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic        d_err;
   logic [31:0] d_rdata;

   logic        flush;
   logic        stall;

   logic        m_req;
   logic [3:0]  m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_ack;
   logic [31:0] m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, flush, m_ack, m_rdata,
      output i_ready, i_err, i_rdata, d_ready, d_err, d_rdata, stall,
             m_req, m_we, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, flush, m_ack, m_rdata,
      input  i_ready, i_err, i_rdata, d_ready, d_err, d_rdata, stall,
             m_req, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory bus, one transaction at a time,
// with alternating priority on contention, a per-transaction watchdog and fetch flush abort.
module mem_bus_arbiter #(
   parameter int MAX_WAIT = 15
) (
   input logic               clk,
   input logic               reset,
   mem_bus_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I, DONE} state_t;

   localparam logic [7:0] WD_LIMIT = 8'(MAX_WAIT - 1);

   state_t      state_q, state_d;
   logic        last_d_q, last_d_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  wd_cnt_q, wd_cnt_d;
   logic        abort_q, abort_d;
   logic        err_q, err_d;
   logic        i_eligible;
   logic        done_ok;
   logic        done_err;

   // last_d_q doubles as the "granted side" marker while a transaction is in flight
   always_comb begin
      state_d    = state_q;
      last_d_d   = last_d_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      wd_cnt_d   = wd_cnt_q;
      abort_d    = abort_q;
      err_d      = err_q;
      i_eligible = bus.i_req & ~bus.flush;

      case (state_q)
         IDLE: begin
            if (bus.d_req && (!i_eligible || !last_d_q)) begin
               state_d  = GRANT_D;
               last_d_d = 1'b1;
               addr_d   = bus.d_addr;
               we_d     = bus.d_we;
               wdata_d  = bus.d_wdata;
               wd_cnt_d = 8'd0;
               err_d    = 1'b0;
            end else if (i_eligible) begin
               state_d  = GRANT_I;
               last_d_d = 1'b0;
               addr_d   = bus.i_addr;
               we_d     = 4'b0000;
               wdata_d  = 32'h0;
               wd_cnt_d = 8'd0;
               err_d    = 1'b0;
            end
         end

         GRANT_D, GRANT_I: begin
            if (state_q == GRANT_I && bus.flush) begin
               abort_d = 1'b1;
            end
            // an ack on the watchdog's last cycle still completes the transfer normally
            if (bus.m_ack) begin
               state_d = DONE;
               rdata_d = bus.m_rdata;
               err_d   = 1'b0;
            end else if (wd_cnt_q == WD_LIMIT) begin
               state_d = DONE;
               rdata_d = 32'h0;
               err_d   = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt_q + 8'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
            abort_d = 1'b0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         addr_q   <= 32'h0;
         we_q     <= 4'b0000;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         wd_cnt_q <= 8'd0;
         abort_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         wd_cnt_q <= wd_cnt_d;
         abort_q  <= abort_d;
         err_q    <= err_d;
      end
   end

   assign done_ok  = (state_q == DONE) & ~err_q;
   assign done_err = (state_q == DONE) & err_q;

   assign bus.m_req   = (state_q == GRANT_D) | (state_q == GRANT_I);
   assign bus.m_we    = we_q;
   assign bus.m_addr  = addr_q;
   assign bus.m_wdata = wdata_q;

   assign bus.d_ready = done_ok & last_d_q;
   assign bus.d_err   = done_err & last_d_q;
   assign bus.i_ready = done_ok & ~last_d_q & ~abort_q;
   assign bus.i_err   = done_err & ~last_d_q & ~abort_q;
   assign bus.i_rdata = rdata_q;
   assign bus.d_rdata = rdata_q;

   assign bus.stall = (bus.i_req & ~bus.i_ready & ~bus.i_err) |
                      (bus.d_req & ~bus.d_ready & ~bus.d_err);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level model predicts grant order,
// bus contents and responses; a memory responder and a response monitor check the DUT.
module tb_mem_bus_arbiter;

   localparam int MAX_WAIT = 15;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rdata;
   } txn_t;

   typedef struct {
      bit          err;
      logic [31:0] data;
   } resp_t;

   logic clk = 1'b0;
   logic reset;

   mem_bus_arbiter_if bus();

   mem_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    fails  = 0;
   txn_t  mq[$];
   resp_t iq[$];
   resp_t dq[$];
   txn_t  dlist[$];
   txn_t  ilist[$];
   bit    last_d = 1'b0;
   bit    abandon = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag_fail(input string name);
      checks++;
      fails++;
      $display("[TB] FAIL %s: event occurred, expected none at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles the bus stays requested: ack cycle, or the full watchdog window on timeout
   function automatic int exp_cycles(input txn_t t);
      return (t.delay <= MAX_WAIT - 1) ? t.delay + 1 : MAX_WAIT;
   endfunction

   function automatic resp_t exp_resp(input txn_t t);
      resp_t r;
      r.err  = (t.delay > MAX_WAIT - 1);
      r.data = r.err ? 32'h0 : t.rdata;
      return r;
   endfunction

   function automatic txn_t rand_txn(input bit fetch);
      txn_t t;
      t.addr  = $urandom;
      t.we    = fetch ? 4'b0000 : (($urandom % 2 == 0) ? 4'b0000 : 4'($urandom_range(1, 15)));
      t.wdata = fetch ? 32'h0 : $urandom;
      t.delay = ($urandom % 5 == 0) ? MAX_WAIT - 1 + $urandom_range(0, 2) : $urandom_range(0, 3);
      t.rdata = $urandom;
      return t;
   endfunction

   task automatic drive_d(input txn_t t);
      bus.d_addr  = t.addr;
      bus.d_we    = t.we;
      bus.d_wdata = t.wdata;
   endtask

   // Memory responder: pops the predicted transaction when the bus opens, checks its
   // contents and duration, and acks after the scheduled delay; acks noise while idle
   initial begin
      txn_t cur;
      bit   have_cur = 1'b0;
      int   bcnt = 0;
      bus.m_ack   = 1'b0;
      bus.m_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.m_req) begin
            if (bcnt == 0) begin
               if (mq.size() == 0) begin
                  flag_fail("bus_unexpected_request");
                  have_cur = 1'b0;
               end else begin
                  cur = mq.pop_front();
                  have_cur = 1'b1;
                  check_output("m_addr", bus.m_addr, cur.addr);
                  check_output("m_we", 32'(bus.m_we), 32'(cur.we));
                  check_output("m_wdata", bus.m_wdata, cur.wdata);
               end
            end else if (have_cur) begin
               check_output("m_addr_stable", bus.m_addr, cur.addr);
               check_output("m_we_stable", 32'(bus.m_we), 32'(cur.we));
            end
            bus.m_ack   = have_cur && (bcnt == cur.delay);
            bus.m_rdata = bus.m_ack ? cur.rdata : $urandom;
            bcnt++;
         end else begin
            if (bcnt != 0 && have_cur && !abandon) begin
               check_output("m_req_cycles", bcnt, exp_cycles(cur));
            end
            bcnt        = 0;
            have_cur    = 1'b0;
            bus.m_ack   = 1'($urandom_range(0, 1));
            bus.m_rdata = $urandom;
         end
      end
   end

   // Response monitor: every ready/err pulse must match the head of that side's queue
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         if (bus.i_ready || bus.i_err) begin
            if (iq.size() == 0) begin
               flag_fail("i_unexpected_response");
            end else begin
               r = iq.pop_front();
               check_output("i_err", 32'(bus.i_err), 32'(r.err));
               check_output("i_ready", 32'(bus.i_ready), 32'(!r.err));
               check_output("i_rdata", bus.i_rdata, r.data);
               check_output("d_rdata_shared", bus.d_rdata, r.data);
            end
         end
         if (bus.d_ready || bus.d_err) begin
            if (dq.size() == 0) begin
               flag_fail("d_unexpected_response");
            end else begin
               r = dq.pop_front();
               check_output("d_err", 32'(bus.d_err), 32'(r.err));
               check_output("d_ready", 32'(bus.d_ready), 32'(!r.err));
               check_output("d_rdata", bus.d_rdata, r.data);
               check_output("i_rdata_shared", bus.i_rdata, r.data);
            end
         end
      end
   end

   task automatic check_drained();
      check_output("bus_queue_drained", mq.size(), 0);
      check_output("i_queue_drained", iq.size(), 0);
      check_output("d_queue_drained", dq.size(), 0);
      mq.delete();
      iq.delete();
      dq.delete();
   endtask

   // Holds each requester's list back to back; the model orders grants by the
   // alternating-priority rule. Called aligned just after a posedge.
   task automatic apply_stimulus(output int lat);
      int nd = dlist.size();
      int ni = ilist.size();
      int di = 0;
      int ii = 0;
      int dk = 0;
      int ik = 0;
      int cyc = 0;
      int budget;
      bit got_d;
      bit got_i;
      while (di < nd || ii < ni) begin
         if (di < nd && (ii >= ni || !last_d)) begin
            mq.push_back(dlist[di]);
            dq.push_back(exp_resp(dlist[di]));
            di++;
            last_d = 1'b1;
         end else begin
            txn_t t = ilist[ii];
            t.we    = 4'b0000;
            t.wdata = 32'h0;
            mq.push_back(t);
            iq.push_back(exp_resp(t));
            ii++;
            last_d = 1'b0;
         end
      end
      budget = (nd + ni) * (MAX_WAIT + 4) + 10;
      lat = -1;
      if (nd > 0) begin
         drive_d(dlist[0]);
         bus.d_req = 1'b1;
      end
      if (ni > 0) begin
         bus.i_addr = ilist[0].addr;
         bus.i_req  = 1'b1;
      end
      while ((dk < nd || ik < ni) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         got_d = bus.d_ready | bus.d_err;
         got_i = bus.i_ready | bus.i_err;
         if ((got_d || got_i) && lat < 0) lat = cyc;
         check_output("stall", 32'(bus.stall),
                      32'((bus.d_req && !got_d) || (bus.i_req && !got_i)));
         tick();
         if (got_d) begin
            dk++;
            if (dk < nd) drive_d(dlist[dk]);
            else bus.d_req = 1'b0;
         end
         if (got_i) begin
            ik++;
            if (ik < ni) bus.i_addr = ilist[ik].addr;
            else bus.i_req = 1'b0;
         end
      end
      if (dk < nd || ik < ni) begin
         checks++;
         fails++;
         $display("[TB] FAIL round_timeout: served d=%0d i=%0d, expected d=%0d i=%0d", dk, ik, nd, ni);
         bus.d_req = 1'b0;
         bus.i_req = 1'b0;
      end
      repeat (4) tick();
      check_drained();
      dlist.delete();
      ilist.delete();
   endtask

   // Fetch flushed k cycles into its grant: bus completes, no fetch response expected
   task automatic apply_flush(input txn_t t, input int k);
      int cyc = 0;
      t.we    = 4'b0000;
      t.wdata = 32'h0;
      mq.push_back(t);
      last_d = 1'b0;
      bus.i_addr = t.addr;
      bus.i_req  = 1'b1;
      while (!bus.m_req && cyc < 5) begin
         tick();
         cyc++;
      end
      check_output("flush_grant_seen", 32'(bus.m_req), 32'd1);
      repeat (k) tick();
      bus.flush = 1'b1;
      bus.i_req = 1'b0;
      tick();
      bus.flush = 1'b0;
      repeat (MAX_WAIT + 4) tick();
      check_output("flush_idle_m_req", 32'(bus.m_req), 32'd0);
      check_drained();
   endtask

   initial begin
      txn_t t;
      int   lat;
      int   cyc;
      int   nd;
      int   ni;
      bus.i_req = 1'b0; bus.i_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 4'b0000; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      bus.flush = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check_output("rst_m_req", 32'(bus.m_req), 32'd0);
      check_output("rst_m_addr", bus.m_addr, 32'h0);
      check_output("rst_m_we", 32'(bus.m_we), 32'd0);
      check_output("rst_m_wdata", bus.m_wdata, 32'h0);
      check_output("rst_rdata", bus.i_rdata, 32'h0);
      check_output("rst_ready_err", 32'({bus.i_ready, bus.i_err, bus.d_ready, bus.d_err}), 32'd0);
      check_output("rst_stall", 32'(bus.stall), 32'd0);

      // Both requesters held from the first active cycle: D, I, D, I
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int n = 0; n < 2; n++) begin
         t = rand_txn(0); t.delay = $urandom_range(0, 2); dlist.push_back(t);
         t = rand_txn(1); t.delay = $urandom_range(0, 2); ilist.push_back(t);
      end
      nd = dlist[0].delay;
      apply_stimulus(lat);
      check_output("first_sample_latency", lat, 2 + exp_cycles(dlist.size() == 0 ? t : t) - exp_cycles(t) + nd + 1);

      // Minimum-latency data read
      t.addr = 32'h100; t.we = 4'b0000; t.wdata = $urandom; t.delay = 0; t.rdata = 32'hDEADBEEF;
      dlist.push_back(t);
      apply_stimulus(lat);
      check_output("read_latency", lat, 3);

      // Data write never acked: watchdog error
      t.addr = $urandom; t.we = 4'b1111; t.wdata = 32'h12345678; t.delay = 1000; t.rdata = $urandom;
      dlist.push_back(t);
      apply_stimulus(lat);
      check_output("timeout_latency", lat, MAX_WAIT + 2);

      // Fetch flushed mid-grant, ack after three wait cycles
      t.addr = 32'h3000; t.we = 4'b0000; t.wdata = 32'h0; t.delay = 3; t.rdata = $urandom;
      apply_flush(t, 1);

      // Flush held in IDLE blocks the fetch grant
      bus.i_addr = $urandom;
      bus.i_req  = 1'b1;
      bus.flush  = 1'b1;
      repeat (3) begin
         tick();
         check_output("flush_blocks_grant", 32'(bus.m_req), 32'd0);
         check_output("flush_blocked_stall", 32'(bus.stall), 32'd1);
      end
      bus.i_req = 1'b0;
      tick();
      // Flush has no effect on a data request
      t = rand_txn(0); t.delay = 1;
      dlist.push_back(t);
      apply_stimulus(lat);
      bus.flush = 1'b0;

      // Reset asserted mid-way through a data grant
      t = rand_txn(0); t.we = 4'b1111; t.delay = 1000;
      mq.push_back(t);
      drive_d(t);
      bus.d_req = 1'b1;
      cyc = 0;
      while (!bus.m_req && cyc < 5) begin
         tick();
         cyc++;
      end
      check_output("rst_grant_seen", 32'(bus.m_req), 32'd1);
      tick();
      #2;
      abandon = 1'b1;
      reset   = 1'b0;
      #1;
      check_output("async_rst_m_req", 32'(bus.m_req), 32'd0);
      check_output("async_rst_m_addr", bus.m_addr, 32'h0);
      check_output("async_rst_m_we", 32'(bus.m_we), 32'd0);
      check_output("async_rst_m_wdata", bus.m_wdata, 32'h0);
      bus.d_req = 1'b0;
      @(negedge clk);
      check_output("in_rst_d_resp", 32'({bus.d_ready, bus.d_err}), 32'd0);
      check_output("in_rst_rdata", bus.d_rdata, 32'h0);
      tick();
      reset  = 1'b1;
      last_d = 1'b0;
      repeat (MAX_WAIT + 4) tick();
      abandon = 1'b0;
      check_drained();
      t = rand_txn(0); t.delay = 0;
      dlist.push_back(t);
      apply_stimulus(lat);
      check_output("post_rst_latency", lat, 3);

      // Randomized rounds
      for (int r = 0; r < 40; r++) begin
         if ($urandom % 4 == 3) begin
            t = rand_txn(1);
            apply_flush(t, $urandom_range(0, exp_cycles(t) - 1));
         end else begin
            nd = $urandom_range(0, 2);
            ni = $urandom_range(0, 2);
            if (nd + ni == 0) nd = 1;
            for (int n = 0; n < nd; n++) dlist.push_back(rand_txn(0));
            for (int n = 0; n < ni; n++) ilist.push_back(rand_txn(1));
            apply_stimulus(lat);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: watchdog limit in cycles on one bus transaction (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_req input 1 fetch request; i_addr input 32 fetch address.
REQ-005 SHALL have ports i_ready output 1 fetch done pulse; i_err output 1 fetch bus-error pulse; i_rdata output 32 fetch data.
REQ-006 SHALL have ports d_req input 1 data request; d_we input 4 byte enables (0 = read); d_addr input 32; d_wdata input 32.
REQ-007 SHALL have ports d_ready output 1; d_err output 1; d_rdata output 32.
REQ-008 SHALL have ports flush input 1 exception flush (fetch side only); stall output 1 any requester not yet served.
REQ-009 SHALL have memory ports m_req output 1; m_we output 4; m_addr output 32; m_wdata output 32; m_ack input 1; m_rdata input 32.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT_D, GRANT_I, DONE.
REQ-011 IDLE: requests sampled only here; d_req alone -> GRANT_D; i_req alone (flush low) -> GRANT_I; none -> stay.
REQ-012 Both pending in IDLE: GRANT_D unless last_grant==D, then GRANT_I; last_grant updated on every grant.
REQ-013 i_req with flush high in IDLE SHALL NOT be granted that cycle; d_req unaffected by flush.
REQ-014 On IDLE->GRANT_x edge SHALL latch addr, we (fetch: 4'b0000), wdata into registers; m_* driven only from these registers.
REQ-015 m_req SHALL be 1 exactly in GRANT_D/GRANT_I; m_we/m_addr/m_wdata stable while m_req high.
REQ-016 m_ack sampled high in GRANT_x -> DONE next cycle; m_rdata captured into shared rdata register (writes capture m_rdata too).
REQ-017 i_rdata and d_rdata SHALL both equal the shared rdata register.
REQ-018 DONE lasts exactly one cycle, ignores all requests, pulses i_ready or d_ready (granted side), then -> IDLE.
REQ-019 Minimum latency: req sampled edge N, m_req high cycle N+1, ack same cycle, ready high cycle N+2; next grant earliest edge N+3.
REQ-020 Watchdog counter (8 bit) SHALL clear on grant, increment each GRANT_x cycle without m_ack; at count==MAX_WAIT-1 without ack -> DONE with error.
REQ-021 Error DONE SHALL pulse i_err/d_err instead of ready and load rdata with 0; ready and err never both high.
REQ-022 flush high in any cycle of GRANT_I or the entry edge to DONE SHALL set an abort flag; bus transaction completes normally but i_ready/i_err suppressed in DONE.
REQ-023 Abort flag SHALL clear on leaving DONE; flush has no effect on GRANT_D or d_ready/d_err.
REQ-024 stall SHALL be combinational: (i_req & ~i_ready & ~i_err) | (d_req & ~d_ready & ~d_err).
REQ-025 m_ack high outside GRANT_x SHALL be ignored.

Reset
REQ-026 reset low SHALL immediately force IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, rdata=0, counter=0, abort=0, last_grant=I.
REQ-027 While reset low all ready/err outputs SHALL be 0; reset mid-transaction abandons it with no ready/err pulse after release.
REQ-028 First request SHALL be sampled on the first posedge with reset high.

Verification
REQ-029 d_req read addr 0x100, m_ack same cycle as m_req, m_rdata 0xDEADBEEF -> d_ready high 2 cycles after sampling edge, d_rdata=0xDEADBEEF, m_we=0.
REQ-030 i_req and d_req both held after reset -> grant order D, I, D, I; each ready one pulse; stall high until own ready.
REQ-031 i_req addr 0x3000, flush pulse during GRANT_I, m_ack after 3 cycles -> m_req held 4 cycles, no i_ready, return to IDLE.
REQ-032 d_req write we=4'b1111 data 0x12345678, m_ack never -> m_req high exactly MAX_WAIT (15) cycles, then d_err pulse, d_rdata=0.
REQ-033 reset driven low during GRANT_D with m_ack pending -> m_req 0 without clock edge; after release no d_ready/d_err; next request served normally.
